// File: rtl/sram_arbiter_2p.sv
// -----------------------------------------------------------------------------
// sram_arbiter_2p
//
// Purpose:
//   Shares one 32-bit SRAM controller between two masters. Typically the
//   instruction fetch unit is master 0 and the load/store unit is master 1.
//   The arbiter picks one requester and drives the controller strobe interface
//   until the controller acknowledges. It then returns the read data and a
//   one-cycle ack to the winning master.
//   Arbitration is round-robin by default, or master 0 always wins ties when
//   FIXED_PRIO is set. A watchdog ends a transaction with an error flag if the
//   controller does not acknowledge in time.
//
// Parameters:
//   FIXED_PRIO      1: master 0 wins every tie. 0: round-robin.
//   TIMEOUT_CYCLES  BUSY cycles without i_s_ack before a forced error
//                   completion (>= 2).
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_mN_addr/wdata/bmask master N request fields, held until its ack
//   i_mN_wren/rden        master N request strobes; both high means a write
//   o_mN_rdata            master N read data, valid with o_mN_ack
//   o_mN_ack              master N one-cycle completion pulse
//   o_mN_err              master N timeout flag, valid with o_mN_ack
//   o_s_addr/wdata/bmask  to controller i_ADDR / i_WDATA / i_BMASK
//   o_s_wren/rden         to controller i_WREN / i_RDEN (never both high)
//   i_s_rdata, i_s_ack    from controller o_RDATA / o_ACK
//   o_busy                transaction in flight (BUSY and RESP)
//   o_grant               index of the current or last granted master
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module sram_arbiter_2p #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Master 0
  input  logic [17:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_bmask,
  input  logic        i_m0_wren,
  input  logic        i_m0_rden,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  // Master 1
  input  logic [17:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_bmask,
  input  logic        i_m1_wren,
  input  logic        i_m1_rden,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  // Controller side
  output logic [17:0] o_s_addr,
  output logic [31:0] o_s_wdata,
  output logic [3:0]  o_s_bmask,
  output logic        o_s_wren,
  output logic        o_s_rden,
  input  logic [31:0] i_s_rdata,
  input  logic        i_s_ack,
  // Status
  output logic        o_busy,
  output logic        o_grant
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_last_grant;
  logic            r_grant;
  logic            r_busy;

  logic [17:0]     r_s_addr;
  logic [31:0]     r_s_wdata;
  logic [3:0]      r_s_bmask;
  logic            r_s_wren;
  logic            r_s_rden;

  logic [31:0]     r_m0_rdata;
  logic            r_m0_ack;
  logic            r_m0_err;
  logic [31:0]     r_m1_rdata;
  logic            r_m1_ack;
  logic            r_m1_err;

  // ---------------------------------------------------------------------------
  // Request decode and winner selection (only consumed in StIdle)
  // ---------------------------------------------------------------------------
  logic        w_req0;
  logic        w_req1;
  logic        w_any_req;
  logic        w_pick;
  logic [17:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_bmask;
  logic        w_sel_wren;
  logic        w_sel_rden;

  assign w_req0    = i_m0_wren | i_m0_rden;
  assign w_req1    = i_m1_wren | i_m1_rden;
  assign w_any_req = w_req0 | w_req1;

  always_comb begin
    w_pick = 1'b0;
    if (w_req0 && w_req1) begin
      // On a tie, round-robin hands the bus to whoever did not have it last.
      w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
    end else if (w_req1) begin
      w_pick = 1'b1;
    end
  end

  always_comb begin
    w_sel_addr  = i_m0_addr;
    w_sel_wdata = i_m0_wdata;
    w_sel_bmask = i_m0_bmask;
    w_sel_wren  = i_m0_wren;
    w_sel_rden  = i_m0_rden;
    if (w_pick) begin
      w_sel_addr  = i_m1_addr;
      w_sel_wdata = i_m1_wdata;
      w_sel_bmask = i_m1_bmask;
      w_sel_wren  = i_m1_wren;
      w_sel_rden  = i_m1_rden;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;  // master 0 wins the first tie
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_s_bmask    <= '0;
      r_s_wren     <= 1'b0;
      r_s_rden     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m0_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_rdata   <= '0;
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
    end else begin
      // Acks and errors are single-cycle pulses; they only rise on the
      // transition into StResp.
      r_m0_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m1_err <= 1'b0;

      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_s_addr     <= w_sel_addr;
            r_s_wdata    <= w_sel_wdata;
            r_s_bmask    <= w_sel_bmask;
            // A request with both strobes set is a write; rden is masked off.
            r_s_wren     <= w_sel_wren;
            r_s_rden     <= w_sel_rden & ~w_sel_wren;
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            r_state      <= StBusy;
          end
        end

        StBusy: begin
          if (i_s_ack) begin
            // Writes latch the bus too; the value is meaningless to the master.
            r_s_wren <= 1'b0;
            r_s_rden <= 1'b0;
            if (r_grant) begin
              r_m1_rdata <= i_s_rdata;
              r_m1_ack   <= 1'b1;
            end else begin
              r_m0_rdata <= i_s_rdata;
              r_m0_ack   <= 1'b1;
            end
            r_state <= StResp;
          end else if (r_cnt == CntMax) begin
            // Watchdog expiry: complete the hung transaction with an error.
            r_s_wren <= 1'b0;
            r_s_rden <= 1'b0;
            if (r_grant) begin
              r_m1_rdata <= '0;
              r_m1_ack   <= 1'b1;
              r_m1_err   <= 1'b1;
            end else begin
              r_m0_rdata <= '0;
              r_m0_ack   <= 1'b1;
              r_m0_err   <= 1'b1;
            end
            r_state <= StResp;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StResp: begin
          // Requests are not looked at here: a master still requesting in its
          // ack cycle is re-evaluated from StIdle on the following cycle.
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_m0_rdata = r_m0_rdata;
  assign o_m0_ack   = r_m0_ack;
  assign o_m0_err   = r_m0_err;
  assign o_m1_rdata = r_m1_rdata;
  assign o_m1_ack   = r_m1_ack;
  assign o_m1_err   = r_m1_err;
  assign o_s_addr   = r_s_addr;
  assign o_s_wdata  = r_s_wdata;
  assign o_s_bmask  = r_s_bmask;
  assign o_s_wren   = r_s_wren;
  assign o_s_rden   = r_s_rden;
  assign o_busy     = r_busy;
  assign o_grant    = r_grant;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter_2p
//
// Two arbiter instances with TIMEOUT_CYCLES = 8: index 0 is round-robin,
// index 1 is fixed priority. The bench plays both masters and the SRAM
// controller. Cycle n of a transaction is counted from the cycle in which the
// request is first presented in idle (n = 0).
// -----------------------------------------------------------------------------
module tb_sram_arbiter_2p;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic [17:0] m_addr  [2][2];
  logic [31:0] m_wdata [2][2];
  logic [3:0]  m_bmask [2][2];
  logic        m_wren  [2][2];
  logic        m_rden  [2][2];
  logic [31:0] m_rdata [2][2];
  logic        m_ack   [2][2];
  logic        m_err   [2][2];
  logic [17:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_bmask [2];
  logic        s_wren  [2];
  logic        s_rden  [2];
  logic [31:0] s_rdata [2];
  logic        s_ack   [2];
  logic        busy    [2];
  logic        grant   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter_2p #(
      .FIXED_PRIO     (g),
      .TIMEOUT_CYCLES (TO)
    ) u_dut (
      .i_clk      (clk),
      .i_reset    (rst[g]),
      .i_m0_addr  (m_addr[g][0]),
      .i_m0_wdata (m_wdata[g][0]),
      .i_m0_bmask (m_bmask[g][0]),
      .i_m0_wren  (m_wren[g][0]),
      .i_m0_rden  (m_rden[g][0]),
      .o_m0_rdata (m_rdata[g][0]),
      .o_m0_ack   (m_ack[g][0]),
      .o_m0_err   (m_err[g][0]),
      .i_m1_addr  (m_addr[g][1]),
      .i_m1_wdata (m_wdata[g][1]),
      .i_m1_bmask (m_bmask[g][1]),
      .i_m1_wren  (m_wren[g][1]),
      .i_m1_rden  (m_rden[g][1]),
      .o_m1_rdata (m_rdata[g][1]),
      .o_m1_ack   (m_ack[g][1]),
      .o_m1_err   (m_err[g][1]),
      .o_s_addr   (s_addr[g]),
      .o_s_wdata  (s_wdata[g]),
      .o_s_bmask  (s_bmask[g]),
      .o_s_wren   (s_wren[g]),
      .o_s_rden   (s_rden[g]),
      .i_s_rdata  (s_rdata[g]),
      .i_s_ack    (s_ack[g]),
      .o_busy     (busy[g]),
      .o_grant    (grant[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last [2];  // reference: master that won the previous arbitration

  typedef struct {
    int          m;
    bit          wr;
    bit          rd;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bm;
    int          k;      // controller ack cycle; 0 = never
    logic [31:0] srd;
    bit          e_wr;   // expected strobe: 1 = write, 0 = read
    int          ackc;   // expected master ack cycle
    logic [31:0] e_rd;
    bit          e_err;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int m, input bit wr, input bit rd,
                       input logic [17:0] a, input logic [31:0] wd, input logic [3:0] bm);
    m_wren[d][m]  = wr;
    m_rden[d][m]  = rd;
    m_addr[d][m]  = a;
    m_wdata[d][m] = wd;
    m_bmask[d][m] = bm;
  endtask

  task automatic idle_m(input int d, input int m);
    drive(d, m, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
  endtask

  task automatic chk_reset_state(input int d, input string tag);
    chk1({tag, " s_wren"}, s_wren[d], 1'b0);
    chk1({tag, " s_rden"}, s_rden[d], 1'b0);
    chk1({tag, " busy"}, busy[d], 1'b0);
    chk1({tag, " grant"}, grant[d], 1'b0);
    chk({tag, " s_addr"}, 32'(s_addr[d]), 32'h0);
    chk({tag, " s_wdata"}, s_wdata[d], 32'h0);
    chk({tag, " s_bmask"}, 32'(s_bmask[d]), 32'h0);
    for (int m = 0; m < 2; m++) begin
      chk1({tag, " ack"}, m_ack[d][m], 1'b0);
      chk1({tag, " err"}, m_err[d][m], 1'b0);
      chk({tag, " rdata"}, m_rdata[d][m], 32'h0);
    end
  endtask

  // Called in cycle 0 with the requests already driven. Plays the controller,
  // checks every cycle up to one past the expected ack, and returns in that
  // idle cycle so the caller can change requests before the next edge.
  task automatic do_txn(input int d, input int w, input int k, input logic [31:0] srd,
                        input bit e_wr, input logic [17:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_bm, input int ackc, input logic [31:0] e_rd,
                        input bit e_err);
    int          o;
    logic [31:0] o_rd;
    bit          str;
    o    = 1 - w;
    o_rd = m_rdata[d][o];
    for (int n = 1; n <= ackc + 1; n++) begin
      tick();
      str = (n < ackc);
      chk1("s_wren", s_wren[d], str && e_wr);
      chk1("s_rden", s_rden[d], str && !e_wr);
      if (str) begin
        chk("s_addr", 32'(s_addr[d]), 32'(e_addr));
        chk("s_wdata", s_wdata[d], e_wdata);
        chk("s_bmask", 32'(s_bmask[d]), 32'(e_bm));
      end
      chk1("win_ack", m_ack[d][w], n == ackc);
      chk1("lose_ack", m_ack[d][o], 1'b0);
      chk1("lose_err", m_err[d][o], 1'b0);
      chk("lose_rdata", m_rdata[d][o], o_rd);
      chk1("busy", busy[d], n <= ackc);
      chk1("grant", grant[d], w != 0);
      if (n == ackc) begin
        chk("win_rdata", m_rdata[d][w], e_rd);
        chk1("win_err", m_err[d][w], e_err);
      end else begin
        chk1("win_err_idle", m_err[d][w], 1'b0);
      end
      s_ack[d]   = (n == k);
      s_rdata[d] = (n == k) ? srd : $urandom();
    end
    s_ack[d] = 1'b0;
    model_last[d] = (w != 0);
  endtask

  // Random-test reference state
  bit          pend [2];
  bit          rwr  [2];
  bit          rrd  [2];
  logic [17:0] ra   [2];
  logic [31:0] rwd  [2];
  logic [3:0]  rbm  [2];

  initial begin
    int          rr_order [4];
    int          w;
    int          k;
    int          op;
    int          ackc;
    bit          ok;
    logic [31:0] srd;

    tbl[0] = '{0, 1'b0, 1'b1, 18'h00010, 32'h0, 4'h0, 5, 32'hCAFE_F00D,
               1'b0, 6, 32'hCAFE_F00D, 1'b0};
    tbl[1] = '{1, 1'b1, 1'b1, 18'h3FFFF, 32'h1234_5678, 4'b0011, 2, 32'hAAAA_5555,
               1'b1, 3, 32'hAAAA_5555, 1'b0};
    tbl[2] = '{0, 1'b1, 1'b0, 18'h20000, 32'hFFFF_0000, 4'b1111, 1, 32'h1111_1111,
               1'b1, 2, 32'h1111_1111, 1'b0};
    tbl[3] = '{0, 1'b0, 1'b1, 18'h00ABC, 32'h0, 4'h0, 0, 32'h0,
               1'b0, 9, 32'h0, 1'b1};
    tbl[4] = '{1, 1'b0, 1'b1, 18'h12345, 32'h0, 4'h0, 8, 32'hDEAD_BEEF,
               1'b0, 9, 32'hDEAD_BEEF, 1'b0};
    tbl[5] = '{1, 1'b0, 1'b1, 18'h00001, 32'h0, 4'h0, 9, 32'h7777_7777,
               1'b0, 9, 32'h0, 1'b1};
    tbl[6] = '{0, 1'b0, 1'b1, 18'h00020, 32'h0, 4'h0, 3, 32'h0BAD_F00D,
               1'b0, 4, 32'h0BAD_F00D, 1'b0};
    rr_order = '{0, 1, 0, 1};

    for (int d = 0; d < 2; d++) begin
      rst[d]     = 1'b1;
      s_ack[d]   = 1'b0;
      s_rdata[d] = 32'h0;
      idle_m(d, 0);
      idle_m(d, 1);
      model_last[d] = 1'b1;
    end
    tick();
    tick();
    chk_reset_state(0, "reset0");
    chk_reset_state(1, "reset1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Round-robin: both masters request continuously.
    drive(0, 0, 1'b0, 1'b1, 18'h00100, 32'h0, 4'h0);
    drive(0, 1, 1'b1, 1'b0, 18'h00200, 32'h55AA_55AA, 4'b1100);
    for (int i = 0; i < 4; i++) begin
      w = rr_order[i];
      if (w == 0) begin
        do_txn(0, 0, 2, 32'h1000 + i, 1'b0, 18'h00100, 32'h0, 4'h0, 3, 32'h1000 + i, 1'b0);
      end else begin
        do_txn(0, 1, 2, 32'h2000 + i, 1'b1, 18'h00200, 32'h55AA_55AA, 4'b1100, 3,
               32'h2000 + i, 1'b0);
      end
    end
    idle_m(0, 0);
    idle_m(0, 1);
    tick();

    // Fixed priority: m0 keeps winning until it stops requesting.
    drive(1, 0, 1'b0, 1'b1, 18'h00300, 32'h0, 4'h0);
    drive(1, 1, 1'b0, 1'b1, 18'h00400, 32'h0, 4'h0);
    do_txn(1, 0, 1, 32'hA1, 1'b0, 18'h00300, 32'h0, 4'h0, 2, 32'hA1, 1'b0);
    do_txn(1, 0, 3, 32'hA2, 1'b0, 18'h00300, 32'h0, 4'h0, 4, 32'hA2, 1'b0);
    do_txn(1, 0, 2, 32'hA3, 1'b0, 18'h00300, 32'h0, 4'h0, 3, 32'hA3, 1'b0);
    idle_m(1, 0);
    do_txn(1, 1, 2, 32'hB1, 1'b0, 18'h00400, 32'h0, 4'h0, 3, 32'hB1, 1'b0);
    idle_m(1, 1);
    tick();

    // Table of single-master transactions.
    for (int i = 0; i < 7; i++) begin
      drive(0, tbl[i].m, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].bm);
      do_txn(0, tbl[i].m, tbl[i].k, tbl[i].srd, tbl[i].e_wr, tbl[i].addr, tbl[i].wdata,
             tbl[i].bm, tbl[i].ackc, tbl[i].e_rd, tbl[i].e_err);
      idle_m(0, tbl[i].m);
    end
    tick();

    // Reset in the middle of a read, then a stray controller ack.
    drive(0, 0, 1'b0, 1'b1, 18'h0ABCD, 32'h0, 4'h0);
    tick();
    chk1("midrst busy", busy[0], 1'b1);
    chk1("midrst s_rden", s_rden[0], 1'b1);
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    idle_m(0, 0);
    chk_reset_state(0, "midrst");
    s_ack[0]   = 1'b1;
    s_rdata[0] = 32'hFFFF_FFFF;
    tick();
    s_ack[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("late_ack m0", m_ack[0][0], 1'b0);
      chk1("late_ack m1", m_ack[0][1], 1'b0);
      chk1("late_ack busy", busy[0], 1'b0);
      chk1("late_ack s_rden", s_rden[0], 1'b0);
      chk("late_ack rdata", m_rdata[0][0], 32'h0);
      tick();
    end
    model_last[0] = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 18'h00044, 32'h0, 4'h0);
    do_txn(0, 0, 4, 32'h4444_0000, 1'b0, 18'h00044, 32'h0, 4'h0, 5, 32'h4444_0000, 1'b0);
    idle_m(0, 0);

    // Randomized rounds against the transaction-level model.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int r = 0; r < 40; r++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 1) == 1)) begin
          op      = int'($urandom_range(1, 3));
          pend[m] = 1'b1;
          rwr[m]  = op[1];
          rrd[m]  = op[0];
          ra[m]   = 18'($urandom());
          rwd[m]  = $urandom();
          rbm[m]  = 4'($urandom());
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        rwr[0]  = 1'b0;
        rrd[0]  = 1'b1;
        ra[0]   = 18'($urandom());
        rwd[0]  = $urandom();
        rbm[0]  = 4'($urandom());
      end
      for (int m = 0; m < 2; m++) begin
        if (pend[m]) drive(0, m, rwr[m], rrd[m], ra[m], rwd[m], rbm[m]);
        else idle_m(0, m);
      end
      if (pend[0] && pend[1]) w = model_last[0] ? 0 : 1;
      else w = pend[1] ? 1 : 0;
      k    = int'($urandom_range(0, TO + 1));
      srd  = $urandom();
      ok   = (k >= 1) && (k <= TO);
      ackc = ok ? k + 1 : TO + 1;
      do_txn(0, w, k, srd, rwr[w], ra[w], rwd[w], rbm[w], ackc, ok ? srd : 32'h0, !ok);
      pend[w] = 1'b0;
      if (!pend[w]) idle_m(0, w);
    end
    idle_m(0, 0);
    idle_m(0, 1);
    tick();
    chk1("final busy", busy[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
